ram2_arbiter: RTL and testbench
===============================

RAM2_ARBITER -- requirements
Module: ram2_arbiter

Interface
REQ-001 Parameter ADDR_W, 18, RAM2 word-address width.
REQ-002 Parameter DATA_W, 16, RAM2 data width.
REQ-003 Parameter STARVE_LIMIT, 3, max consecutive contended EXE wins before IF is forced (legal 1..7).
REQ-004 Parameter TIMEOUT_CYCLES, 15, BUSY cycles without mem_done before abort (used only with macro; legal 1..255).
REQ-005 clk  in  1  system clock, all logic on rising edge.
REQ-006 rst  in  1  reset, synchronous, active-high.
REQ-007 exe_req  in  1  EXE access request, level, held until exe_ack.
REQ-008 exe_we  in  1  1 = write, 0 = read; valid with exe_req.
REQ-009 exe_addr  in  ADDR_W  EXE address.
REQ-010 exe_wdata  in  DATA_W  EXE write data.
REQ-011 exe_ack  out  1  one-cycle completion pulse to EXE.
REQ-012 if_req  in  1  instruction-fetch read request, level, held until if_ack.
REQ-013 if_addr  in  ADDR_W  fetch address.
REQ-014 if_ack  out  1  one-cycle completion pulse to IF.
REQ-015 rdata  out  DATA_W  read data, valid in the ack cycle, held until next capture.
REQ-016 mem_req  out  1  request to RAM2 controller, registered, high until mem_done is sampled.
REQ-017 mem_we  out  1  write select to controller.
REQ-018 mem_addr  out  ADDR_W  latched address to controller.
REQ-019 mem_wdata  out  DATA_W  latched write data to controller.
REQ-020 mem_done  in  1  controller completion, sampled only in BUSY.
REQ-021 mem_rdata  in  DATA_W  controller read data, valid with mem_done.
REQ-022 grant  out  2  current owner: 00 none, 01 EXE, 10 IF.
REQ-023 timeout_err  out  1  sticky abort flag.

Function
REQ-024 FSM states SHALL be IDLE, BUSY, ACK; no other reachable state; any illegal encoding SHALL return to IDLE next cycle.
REQ-025 IDLE: if any request is high, arbitrate, latch winner's we/addr/wdata into mem_we/mem_addr/mem_wdata, set grant, set mem_req=1, go BUSY; else stay IDLE, grant=00.
REQ-026 Arbitration: EXE wins unless both requests high and starve_cnt==STARVE_LIMIT, in which case IF wins; IF requests are always reads (mem_we=0).
REQ-027 starve_cnt (3 bits): +1 when EXE wins while if_req high; cleared when IF is granted; saturates at STARVE_LIMIT.
REQ-028 BUSY: mem_req, mem_we, mem_addr, mem_wdata SHALL be stable; on mem_done=1 capture mem_rdata into rdata (reads only; writes leave rdata unchanged), drop mem_req, go ACK.
REQ-029 ACK: pulse exe_ack or if_ack per grant for exactly one cycle, then go IDLE with grant=00; requests are not sampled in ACK.
REQ-030 Minimum latency: request sampled in IDLE at edge N, mem_done high at edge N+1, ack high during cycle after edge N+2; back-to-back grants are separated by at least one IDLE cycle.
REQ-031 A requester dropping req mid-transaction SHALL NOT abort it; the ack still pulses.
REQ-032 exe_ack and if_ack SHALL never be high in the same cycle; at most one transaction outstanding.

Reset
REQ-033 With rst=1 at a rising edge: state=IDLE, grant=00, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, rdata=0, exe_ack=0, if_ack=0, starve_cnt=0, timeout_err=0.
REQ-034 Reset during BUSY SHALL drop mem_req on the next edge with no ack issued.

Configuration
REQ-035 Macro RAM2_ARB_TIMEOUT_EN defined: an 8-bit BUSY counter cleared on entering BUSY; when it reaches TIMEOUT_CYCLES without mem_done, drop mem_req, set rdata to all ones, set timeout_err (sticky until rst), go ACK; undefined: BUSY waits indefinitely, no counter, timeout_err tied 0.

Verification
REQ-036 exe_req=1 read, exe_addr=0x00010, mem_done one cycle after issue with mem_rdata=0xBEEF -> mem_addr=0x00010, mem_we=0, exe_ack one cycle, rdata=0xBEEF.
REQ-037 exe_req and if_req held high, exe writes 0x1234, mem_done immediate -> grants EXE,EXE,EXE,IF (STARVE_LIMIT=3), starve_cnt back to 0 after IF grant.
REQ-038 if_req only, if_addr=0x3FFFF, mem_done after 5 BUSY cycles -> mem_req high exactly 6 cycles, if_ack one cycle, exe_ack stays 0.
REQ-039 rst=1 asserted in second BUSY cycle -> next cycle mem_req=0, grant=00, no ack pulse, all outputs at reset values.
REQ-040 RAM2_ARB_TIMEOUT_EN defined, mem_done never asserted, TIMEOUT_CYCLES=15 -> after 15 BUSY cycles exe_ack pulses, rdata=0xFFFF, timeout_err=1 until rst; macro undefined -> FSM stays in BUSY, timeout_err=0.

Source files
------------

// File: rtl/ram2_arbiter_if.sv
// Bus bundle between the EXE/IF requesters, the RAM2 arbiter and the RAM2 controller.
// The arbiter takes the slave side; requesters and the controller sit on the master side.
interface ram2_arbiter_if #(
  parameter int ADDR_W = 18,
  parameter int DATA_W = 16
);
  logic              exe_req;
  logic              exe_we;
  logic [ADDR_W-1:0] exe_addr;
  logic [DATA_W-1:0] exe_wdata;
  logic              exe_ack;
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_ack;
  logic [DATA_W-1:0] rdata;
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_done;
  logic [DATA_W-1:0] mem_rdata;
  logic [1:0]        grant;
  logic              timeout_err;

  modport slave (
    input  exe_req, exe_we, exe_addr, exe_wdata, if_req, if_addr, mem_done, mem_rdata,
    output exe_ack, if_ack, rdata, mem_req, mem_we, mem_addr, mem_wdata, grant, timeout_err
  );

  modport master (
    output exe_req, exe_we, exe_addr, exe_wdata, if_req, if_addr, mem_done, mem_rdata,
    input  exe_ack, if_ack, rdata, mem_req, mem_we, mem_addr, mem_wdata, grant, timeout_err
  );
endinterface

// File: rtl/ram2_arbiter.sv
// Two-port (EXE read/write, IF read) arbiter in front of the RAM2 controller, with IF anti-starvation.
// Optional BUSY watchdog enabled by defining RAM2_ARB_TIMEOUT_EN.
module ram2_arbiter #(
  parameter int ADDR_W         = 18,
  parameter int DATA_W         = 16,
  parameter int STARVE_LIMIT   = 3,
  parameter int TIMEOUT_CYCLES = 15
) (
  input  logic           clk,
  input  logic           rst,
  ram2_arbiter_if.slave  bus
);

  if (STARVE_LIMIT < 1 || STARVE_LIMIT > 7 || TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255)
  begin : g_bad_param
    $error("ram2_arbiter: STARVE_LIMIT or TIMEOUT_CYCLES out of range");
  end

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    BUSY = 2'b01,
    ACK  = 2'b10
  } state_t;

  localparam logic [1:0] GNT_NONE = 2'b00;
  localparam logic [1:0] GNT_EXE  = 2'b01;
  localparam logic [1:0] GNT_IF   = 2'b10;

  state_t     state_q, state_d;
  logic [2:0] starve_cnt;
  logic       start, done, abort, if_wins;

  assign if_wins = bus.if_req && (!bus.exe_req || starve_cnt == 3'(STARVE_LIMIT));

`ifdef RAM2_ARB_TIMEOUT_EN
  logic [7:0] busy_cnt;
  logic       timeout_q;

  // busy_cnt holds the number of BUSY cycles already completed.
  assign abort           = (state_q == BUSY) && !bus.mem_done && busy_cnt == 8'(TIMEOUT_CYCLES - 1);
  assign bus.timeout_err = timeout_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      busy_cnt  <= '0;
      timeout_q <= 1'b0;
    end else begin
      if (start)                busy_cnt <= '0;
      else if (state_q == BUSY) busy_cnt <= busy_cnt + 8'd1;
      if (abort)                timeout_q <= 1'b1;
    end
  end
`else
  assign abort           = 1'b0;
  assign bus.timeout_err = 1'b0;
`endif

  // NOTE: every signal driven here gets its default before the case, so no latch is inferred.
  always_comb begin
    state_d = state_q;
    start   = 1'b0;
    done    = 1'b0;
    case (state_q)
      IDLE: if (bus.exe_req || bus.if_req) begin
        state_d = BUSY;
        start   = 1'b1;
      end
      BUSY: if (bus.mem_done) begin
        state_d = ACK;
        done    = 1'b1;
      end else if (abort) begin
        state_d = ACK;
      end
      ACK:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state is updated with non-blocking assignments and reset synchronously with rst.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      bus.grant     <= GNT_NONE;
      bus.mem_req   <= 1'b0;
      bus.mem_we    <= 1'b0;
      bus.mem_addr  <= '0;
      bus.mem_wdata <= '0;
      bus.rdata     <= '0;
      bus.exe_ack   <= 1'b0;
      bus.if_ack    <= 1'b0;
      starve_cnt    <= '0;
    end else begin
      state_q     <= state_d;
      bus.exe_ack <= 1'b0;
      bus.if_ack  <= 1'b0;

      if (start) begin
        bus.mem_req <= 1'b1;
        if (if_wins) begin
          bus.grant    <= GNT_IF;
          bus.mem_we   <= 1'b0;
          bus.mem_addr <= ADDR_W'(bus.if_addr);
          starve_cnt   <= '0;
        end else begin
          bus.grant     <= GNT_EXE;
          bus.mem_we    <= bus.exe_we;
          bus.mem_addr  <= ADDR_W'(bus.exe_addr);
          bus.mem_wdata <= DATA_W'(bus.exe_wdata);
          if (bus.if_req && starve_cnt != 3'(STARVE_LIMIT))
            starve_cnt <= starve_cnt + 3'd1;
        end
      end

      if (done) begin
        bus.mem_req <= 1'b0;
        if (!bus.mem_we) bus.rdata <= bus.mem_rdata;
      end else if (abort) begin
        bus.mem_req <= 1'b0;
        bus.rdata   <= '1;
      end

      // The ack pulse lands in the following IDLE cycle, after grant is released.
      if (state_q == ACK) begin
        bus.exe_ack <= (bus.grant == GNT_EXE);
        bus.if_ack  <= (bus.grant == GNT_IF);
        bus.grant   <= GNT_NONE;
      end
    end
  end

endmodule

// File: tb/tb_ram2_arbiter.sv
// Scoreboard bench for ram2_arbiter: directed transactions queue the expected ack owner and read data,
// an independent monitor checks them when an ack appears; a controller model answers mem_req.
module tb_ram2_arbiter;
  localparam int ADDR_W         = 18;
  localparam int DATA_W         = 16;
  localparam int STARVE_LIMIT   = 3;
  localparam int TIMEOUT_CYCLES = 15;

  typedef struct {
    logic        is_if;
    logic [15:0] rdata;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ram2_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  ram2_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W),
    .STARVE_LIMIT(STARVE_LIMIT), .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  int          pass_cnt  = 0;
  int          total_cnt = 0;
  int          done_delay = 0;
  logic [15:0] mem_value  = '0;
  logic [15:0] exp_rdata  = '0;
  exp_t        sb_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
  endtask

  // Controller model: raise mem_done for one cycle after done_delay BUSY cycles (never if negative).
  initial begin
    int seen;
    seen = 0;
    bus.mem_done  = 1'b0;
    bus.mem_rdata = '0;
    forever begin
      @(negedge clk);
      if (rst || !bus.mem_req || bus.mem_done) begin
        bus.mem_done = 1'b0;
        if (!bus.mem_req) seen = 0;
      end else begin
        if (done_delay >= 0 && seen == done_delay) begin
          bus.mem_done  = 1'b1;
          bus.mem_rdata = mem_value;
        end
        seen++;
      end
    end
  end

  // Monitor: every ack must match the oldest queued expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (bus.exe_ack || bus.if_ack) begin
        if (sb_q.size() == 0) begin
          check("unexpected_ack", {30'd0, bus.exe_ack, bus.if_ack}, 32'd0);
        end else begin
          e = sb_q.pop_front();
          check("ack_owner", {30'd0, bus.exe_ack, bus.if_ack}, e.is_if ? 32'd1 : 32'd2);
          check("ack_rdata", bus.rdata, e.rdata);
        end
      end
    end
  end

  task automatic wait_mem_req(input string name);
    int n = 0;
    while (!bus.mem_req && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!bus.mem_req) check({name, "_mem_req_wait"}, bus.mem_req, 1);
  endtask

  task automatic wait_ack(input string name);
    int n = 0;
    while (!(bus.exe_ack || bus.if_ack) && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (!(bus.exe_ack || bus.if_ack)) check({name, "_ack_wait"}, {bus.exe_ack, bus.if_ack}, 2'b01);
  endtask

  task automatic check_reset_outputs(input string name);
    check({name, "_grant"},     bus.grant,       0);
    check({name, "_mem_req"},   bus.mem_req,     0);
    check({name, "_mem_we"},    bus.mem_we,      0);
    check({name, "_mem_addr"},  bus.mem_addr,    0);
    check({name, "_mem_wdata"}, bus.mem_wdata,   0);
    check({name, "_rdata"},     bus.rdata,       0);
    check({name, "_acks"},      {bus.exe_ack, bus.if_ack}, 0);
    check({name, "_tmo_err"},   bus.timeout_err, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0] gseq [5];
    int         n;
    logic       is_if;
    gseq = '{2'b01, 2'b01, 2'b01, 2'b10, 2'b01};

    rst = 1'b1;
    bus.exe_req = 1'b0; bus.exe_we = 1'b0; bus.exe_addr = '0; bus.exe_wdata = '0;
    bus.if_req  = 1'b0; bus.if_addr = '0;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b0;

    // Single EXE read at 0x00010 returning 0xBEEF with immediate mem_done.
    @(negedge clk);
    mem_value = 16'hBEEF; done_delay = 0;
    bus.exe_req = 1'b1; bus.exe_we = 1'b0; bus.exe_addr = 18'h00010;
    sb_q.push_back('{is_if: 1'b0, rdata: 16'hBEEF});
    exp_rdata = 16'hBEEF;
    wait_mem_req("t1");
    check("t1_mem_addr", bus.mem_addr, 18'h00010);
    check("t1_mem_we",   bus.mem_we,   0);
    check("t1_grant",    bus.grant,    2'b01);
    wait_ack("t1");
    bus.exe_req = 1'b0;

    // Both requesters held: EXE writes win three times, then IF is forced, then EXE again.
    @(negedge clk);
    mem_value = 16'h0F0F;
    bus.exe_req = 1'b1; bus.exe_we = 1'b1; bus.exe_addr = 18'h00020; bus.exe_wdata = 16'h1234;
    bus.if_req  = 1'b1; bus.if_addr = 18'h00100;
    for (int k = 0; k < 5; k++) begin
      wait_mem_req("t2");
      is_if = (gseq[k] == 2'b10);
      check("t2_grant",  bus.grant,  gseq[k]);
      check("t2_mem_we", bus.mem_we, is_if ? 0 : 1);
      check("t2_mem_addr", bus.mem_addr, is_if ? 18'h00100 : 18'h00020);
      if (!is_if) check("t2_mem_wdata", bus.mem_wdata, 16'h1234);
      if (is_if) exp_rdata = 16'h0F0F;
      sb_q.push_back('{is_if: is_if, rdata: exp_rdata});
      wait_ack("t2");
    end
    bus.exe_req = 1'b0; bus.if_req = 1'b0;

    // IF read at top address, mem_done after 5 BUSY cycles; IF drops req mid-transaction.
    @(negedge clk);
    mem_value = 16'h5A5A; done_delay = 5;
    bus.if_req = 1'b1; bus.if_addr = 18'h3FFFF;
    wait_mem_req("t3");
    check("t3_grant",    bus.grant,    2'b10);
    check("t3_mem_addr", bus.mem_addr, 18'h3FFFF);
    check("t3_mem_we",   bus.mem_we,   0);
    sb_q.push_back('{is_if: 1'b1, rdata: 16'h5A5A});
    bus.if_req = 1'b0;
    n = 0;
    while (bus.mem_req && n < 40) begin
      n++;
      @(negedge clk);
    end
    check("t3_mem_req_cycles", n, 6);
    wait_ack("t3");

    // Reset in the second BUSY cycle aborts silently.
    @(negedge clk);
    done_delay = -1;
    bus.exe_req = 1'b1; bus.exe_we = 1'b0; bus.exe_addr = 18'h00044;
    wait_mem_req("t4");
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_reset_outputs("t4_busy_reset");
    bus.exe_req = 1'b0;
    @(negedge clk);
    rst = 1'b0;

    // mem_done never arrives.
    @(negedge clk);
    bus.exe_req = 1'b1; bus.exe_we = 1'b0; bus.exe_addr = 18'h00055;
    wait_mem_req("t5");
`ifdef RAM2_ARB_TIMEOUT_EN
    sb_q.push_back('{is_if: 1'b0, rdata: 16'hFFFF});
    n = 0;
    while (bus.mem_req && n < 60) begin
      n++;
      @(negedge clk);
    end
    check("t5_busy_cycles", n, TIMEOUT_CYCLES);
    wait_ack("t5");
    bus.exe_req = 1'b0;
    check("t5_tmo_err", bus.timeout_err, 1);
    repeat (3) @(negedge clk);
    check("t5_tmo_sticky", bus.timeout_err, 1);
    check("t5_rdata_hold", bus.rdata, 16'hFFFF);
    rst = 1'b1;
    @(negedge clk);
    check("t5_tmo_cleared", bus.timeout_err, 0);
    rst = 1'b0;
`else
    repeat (40) @(negedge clk);
    check("t5_still_busy", bus.mem_req, 1);
    check("t5_grant",      bus.grant,   2'b01);
    check("t5_tmo_err",    bus.timeout_err, 0);
    rst = 1'b1;
    bus.exe_req = 1'b0;
    @(negedge clk);
    rst = 1'b0;
`endif

    repeat (2) @(negedge clk);
    check("sb_empty", sb_q.size(), 0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
